// File: rtl/dcpu_bus_arb.sv
// ---------------------------------------------------------------------------
// dcpu_bus_arb
//
// Two-master, one-slave memory bus arbiter. Master 0 is the dcpu core,
// master 1 is a secondary bus master (loader, DMA engine or debug port).
// Both masters and the slave speak the core's cs/we/ack protocol.
//
// A master is granted from IDLE with a registered round-robin decision and
// keeps the grant until the slave acks, the master drops cs (abort) or,
// when enabled, the timeout watchdog fires. Every transaction returns to
// IDLE for one cycle, so back-to-back transactions take at least two
// cycles with a zero-wait slave.
//
// Optional feature macro: BUS_TIMEOUT_EN
//   defined   : a TOW-bit watchdog terminates a BUSY phase that has seen
//               TIMEOUT cycles without i_ack. It acks the master with
//               all-ones data and pulses o_timeout.
//   undefined : no watchdog; a BUSY phase waits for ack or abort forever
//               and o_timeout is tied low.
//
// Parameters
//   W        address / data width
//   TOW      watchdog counter width (BUS_TIMEOUT_EN only)
//   TIMEOUT  busy cycles without ack before forced termination (< 2**TOW)
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_m0_* / o_m0_*         master 0 request side and read data / ack
//   i_m1_* / o_m1_*         master 1 request side and read data / ack
//   o_addr, o_dat, o_we,
//   o_cs, i_dat, i_ack      slave side of the bus
//   o_grant                 registered one-hot grant (bit n = master n)
//   o_timeout               one-cycle pulse on a forced termination
// ---------------------------------------------------------------------------
module dcpu_bus_arb #(
    parameter int W       = 16,
    parameter int TOW     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic         i_clk,
    input  logic         i_reset,

    input  logic [W-1:0] i_m0_addr,
    input  logic [W-1:0] i_m0_dat,
    input  logic         i_m0_we,
    input  logic         i_m0_cs,
    output logic [W-1:0] o_m0_dat,
    output logic         o_m0_ack,

    input  logic [W-1:0] i_m1_addr,
    input  logic [W-1:0] i_m1_dat,
    input  logic         i_m1_we,
    input  logic         i_m1_cs,
    output logic [W-1:0] o_m1_dat,
    output logic         o_m1_ack,

    output logic [W-1:0] o_addr,
    output logic [W-1:0] o_dat,
    output logic         o_we,
    output logic         o_cs,
    input  logic [W-1:0] i_dat,
    input  logic         i_ack,

    output logic [1:0]   o_grant,
    output logic         o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY0 = 2'b01,
        BUSY1 = 2'b10
    } state_t;

    state_t      state;
    logic        r_last;
    logic [1:0]  grant;
    logic        owner_cs;
    logic        tmo_hit;

    // Request line of whichever master currently owns the bus. Used both
    // for abort detection and to qualify the watchdog.
    always_comb begin
        owner_cs = 1'b0;
        case (state)
            BUSY0:   owner_cs = i_m0_cs;
            BUSY1:   owner_cs = i_m1_cs;
            default: owner_cs = 1'b0;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam logic [TOW-1:0] TMO_LIMIT = TOW'(TIMEOUT);
    localparam logic [TOW-1:0] TMO_ONE   = TOW'(1);

    logic [TOW-1:0] tmo_cnt;

    // Watchdog counter: zero on entry to every BUSY phase, then counts
    // the busy cycles that passed without a slave ack. It holds the
    // number of already-elapsed busy cycles, so it reads TIMEOUT during
    // busy cycle TIMEOUT+1.
    always_ff @(posedge i_clk) begin
        if (i_reset || state == IDLE) begin
            tmo_cnt <= '0;
        end else if (!i_ack) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
        end
    end

    // A real ack in the limit cycle wins over the watchdog, and an
    // aborting master (cs low) is simply released rather than timed out.
    assign tmo_hit = (state != IDLE) && owner_cs && !i_ack &&
                     (tmo_cnt == TMO_LIMIT);
`else
    // No watchdog in this build; the expression keeps the timeout
    // parameters referenced so both builds share one parameter list.
    assign tmo_hit = 1'b0 & (TIMEOUT < (1 << TOW));
`endif

    // Bus steering. The granted master's request goes straight through to
    // the slave, and the slave's response goes straight back to it, all in
    // the same cycle. The other master and the IDLE state see zeros. A
    // watchdog termination replaces the slave response with an all-ones
    // ack and pulls cs away from the slave.
    always_comb begin
        o_addr   = '0;
        o_dat    = '0;
        o_we     = 1'b0;
        o_cs     = 1'b0;
        o_m0_dat = '0;
        o_m0_ack = 1'b0;
        o_m1_dat = '0;
        o_m1_ack = 1'b0;
        case (state)
            BUSY0: begin
                o_addr   = i_m0_addr;
                o_dat    = i_m0_dat;
                o_we     = i_m0_we;
                o_cs     = i_m0_cs & ~tmo_hit;
                o_m0_dat = tmo_hit ? {W{1'b1}} : i_dat;
                o_m0_ack = (i_ack & i_m0_cs) | tmo_hit;
            end
            BUSY1: begin
                o_addr   = i_m1_addr;
                o_dat    = i_m1_dat;
                o_we     = i_m1_we;
                o_cs     = i_m1_cs & ~tmo_hit;
                o_m1_dat = tmo_hit ? {W{1'b1}} : i_dat;
                o_m1_ack = (i_ack & i_m1_cs) | tmo_hit;
            end
            default: begin
                o_addr   = '0;
                o_dat    = '0;
            end
        endcase
    end

    assign o_grant   = grant;
    assign o_timeout = tmo_hit;

    // Arbitration FSM with the registered grant vector.
    // r_last remembers the master that most recently completed a
    // transaction (ack or watchdog); on a tie the other master wins.
    // It resets to 1 so the core gets the first tie after reset. An
    // aborted transaction does not count as served and leaves r_last alone.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state  <= IDLE;
            r_last <= 1'b1;
            grant  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (i_m0_cs && (!i_m1_cs || r_last)) begin
                        state <= BUSY0;
                        grant <= 2'b01;
                    end else if (i_m1_cs) begin
                        state <= BUSY1;
                        grant <= 2'b10;
                    end
                end
                BUSY0: begin
                    if (!i_m0_cs) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else if (i_ack || tmo_hit) begin
                        state  <= IDLE;
                        grant  <= 2'b00;
                        r_last <= 1'b0;
                    end
                end
                BUSY1: begin
                    if (!i_m1_cs) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end else if (i_ack || tmo_hit) begin
                        state  <= IDLE;
                        grant  <= 2'b00;
                        r_last <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu_bus_arb.sv
// ---------------------------------------------------------------------------
// tb_dcpu_bus_arb
//
// Directed bench for dcpu_bus_arb. Inputs change 2 time units after each
// rising edge; a reference model of the arbiter (bus owner, last served
// master, busy-cycle count) advances on every rising edge and every DUT
// output is compared against it on each falling edge. Directed sequences
// add hand-computed literal checks at chosen cycles.
// Build with +define+BUS_TIMEOUT_EN to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_dcpu_bus_arb;

    localparam int W       = 16;
    localparam int TOW     = 4;
    localparam int TIMEOUT = 15;
`ifdef BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic [W-1:0]  m0_addr, m0_dat, m1_addr, m1_dat;
    logic          m0_we, m0_cs, m1_we, m1_cs;
    logic [W-1:0]  m0_rdat, m1_rdat;
    logic          m0_ack, m1_ack;
    logic [W-1:0]  bus_addr, bus_dat, s_dat;
    logic          bus_we, bus_cs, s_ack;
    logic [1:0]    grant;
    logic          timeout;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state: which master owns the bus (-1 = none), which
    // master was served last, and how many busy cycles have elapsed.
    int m_owner = -1;
    bit m_last  = 1'b1;
    int m_busy  = 0;

    dcpu_bus_arb #(.W(W), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_m0_addr (m0_addr),
        .i_m0_dat  (m0_dat),
        .i_m0_we   (m0_we),
        .i_m0_cs   (m0_cs),
        .o_m0_dat  (m0_rdat),
        .o_m0_ack  (m0_ack),
        .i_m1_addr (m1_addr),
        .i_m1_dat  (m1_dat),
        .i_m1_we   (m1_we),
        .i_m1_cs   (m1_cs),
        .o_m1_dat  (m1_rdat),
        .o_m1_ack  (m1_ack),
        .o_addr    (bus_addr),
        .o_dat     (bus_dat),
        .o_we      (bus_we),
        .o_cs      (bus_cs),
        .i_dat     (s_dat),
        .i_ack     (s_ack),
        .o_grant   (grant),
        .o_timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // ---- model helpers ----------------------------------------------------
    function automatic bit own_cs();
        if (m_owner == 0) return m0_cs;
        if (m_owner == 1) return m1_cs;
        return 1'b0;
    endfunction

    function automatic bit tmo_now();
        return TMO_EN && (m_owner >= 0) && own_cs() && !s_ack &&
               (m_busy == TIMEOUT);
    endfunction

    function automatic logic [W-1:0] exp_addr();
        if (m_owner == 0) return m0_addr;
        if (m_owner == 1) return m1_addr;
        return '0;
    endfunction

    function automatic logic [W-1:0] exp_wdat();
        if (m_owner == 0) return m0_dat;
        if (m_owner == 1) return m1_dat;
        return '0;
    endfunction

    function automatic bit exp_we();
        if (m_owner == 0) return m0_we;
        if (m_owner == 1) return m1_we;
        return 1'b0;
    endfunction

    function automatic bit exp_ack(input int n);
        return (m_owner == n) && ((s_ack && own_cs()) || tmo_now());
    endfunction

    function automatic logic [W-1:0] exp_rdat(input int n);
        if (m_owner != n) return '0;
        if (tmo_now()) return {W{1'b1}};
        return s_dat;
    endfunction

    function automatic logic [1:0] exp_grant();
        if (m_owner == 0) return 2'b01;
        if (m_owner == 1) return 2'b10;
        return 2'b00;
    endfunction

    // Model advance: bus ownership changes only at rising edges.
    always @(posedge clk) begin
        if (reset) begin
            m_owner <= -1;
            m_last  <= 1'b1;
            m_busy  <= 0;
        end else if (m_owner < 0) begin
            m_busy <= 0;
            if (m0_cs && m1_cs) m_owner <= m_last ? 0 : 1;
            else if (m0_cs)     m_owner <= 0;
            else if (m1_cs)     m_owner <= 1;
        end else begin
            m_busy <= m_busy + 1;
            if (!own_cs()) begin
                m_owner <= -1;
            end else if (s_ack || tmo_now()) begin
                m_last  <= (m_owner == 1);
                m_owner <= -1;
            end
        end
    end

    // Compare process: every output, every cycle, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("o_grant",   grant,    exp_grant());
            checkOutput("o_cs",      bus_cs,   own_cs() && !tmo_now());
            checkOutput("o_addr",    bus_addr, exp_addr());
            checkOutput("o_dat",     bus_dat,  exp_wdat());
            checkOutput("o_we",      bus_we,   exp_we());
            checkOutput("o_m0_ack",  m0_ack,   exp_ack(0));
            checkOutput("o_m1_ack",  m1_ack,   exp_ack(1));
            checkOutput("o_m0_dat",  m0_rdat,  exp_rdat(0));
            checkOutput("o_m1_dat",  m1_rdat,  exp_rdat(1));
            checkOutput("o_timeout", timeout,  tmo_now());
        end
    end

    // ---- stimulus helpers -------------------------------------------------
    task automatic applyStimulus();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clearInputs();
        m0_addr = '0; m0_dat = '0; m0_we = 1'b0; m0_cs = 1'b0;
        m1_addr = '0; m1_dat = '0; m1_we = 1'b0; m1_cs = 1'b0;
        s_ack   = 1'b0;
        s_dat   = 16'hA5A5;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        clearInputs();

        // Reset state
        applyStimulus();
        chk_en = 1'b1;
        settle();
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_cs", bus_cs, 1'b0);
        checkOutput("rst_acks", {m1_ack, m0_ack}, 2'b00);
        applyStimulus();
        reset = 1'b0;

        // Single zero-wait read by m0
        applyStimulus();
        m0_cs = 1'b1; m0_addr = 16'h0010;
        settle();
        checkOutput("rd_idle_grant", grant, 2'b00);
        checkOutput("rd_idle_cs", bus_cs, 1'b0);
        applyStimulus();
        s_ack = 1'b1; s_dat = 16'hBEEF;
        settle();
        checkOutput("rd_grant", grant, 2'b01);
        checkOutput("rd_cs", bus_cs, 1'b1);
        checkOutput("rd_addr", bus_addr, 16'h0010);
        checkOutput("rd_ack", m0_ack, 1'b1);
        checkOutput("rd_dat", m0_rdat, 16'hBEEF);
        applyStimulus();
        clearInputs();
        settle();
        checkOutput("rd_done_grant", grant, 2'b00);

        // Tie right after reset: m0 first, then m1 after one IDLE cycle
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        m0_cs = 1'b1; m0_addr = 16'h0020;
        m1_cs = 1'b1; m1_addr = 16'h0030;
        applyStimulus();
        s_ack = 1'b1; s_dat = 16'h1111;
        settle();
        checkOutput("tie_grant0", grant, 2'b01);
        checkOutput("tie_m1_noack", m1_ack, 1'b0);
        applyStimulus();
        m0_cs = 1'b0; s_ack = 1'b0;
        settle();
        checkOutput("tie_gap", grant, 2'b00);
        applyStimulus();
        s_ack = 1'b1; s_dat = 16'h2222;
        settle();
        checkOutput("tie_grant1", grant, 2'b10);
        checkOutput("tie_m1_dat", m1_rdat, 16'h2222);
        checkOutput("tie_acks", {m1_ack, m0_ack}, 2'b10);
        applyStimulus();
        clearInputs();

        // Round robin: both masters request continuously, one-wait slave
        for (int t = 0; t < 6; t++) begin
            applyStimulus();
            m0_cs = 1'b1; m0_addr = 16'h0A00;
            m1_cs = 1'b1; m1_addr = 16'h0B00;
            s_ack = 1'b0;
            applyStimulus();
            settle();
            checkOutput("rr_grant", grant, (t % 2) ? 2'b10 : 2'b01);
            applyStimulus();
            s_ack = 1'b1; s_dat = 16'h5000 + 16'(t);
            settle();
            checkOutput("rr_acks", {m1_ack, m0_ack}, (t % 2) ? 2'b10 : 2'b01);
        end
        applyStimulus();
        clearInputs();

        // Write by m1 while m0 toggles its request
        applyStimulus();
        m1_cs = 1'b1; m1_we = 1'b1; m1_addr = 16'h0100; m1_dat = 16'h1234;
        applyStimulus();
        m0_cs = 1'b1; m0_addr = 16'h0999;
        settle();
        checkOutput("wr_we", bus_we, 1'b1);
        checkOutput("wr_addr", bus_addr, 16'h0100);
        checkOutput("wr_dat", bus_dat, 16'h1234);
        applyStimulus();
        m0_cs = 1'b0; s_ack = 1'b1;
        settle();
        checkOutput("wr_acks", {m1_ack, m0_ack}, 2'b10);
        applyStimulus();
        clearInputs();

        // Abort by m0, then a stray slave ack in IDLE
        applyStimulus();
        m0_cs = 1'b1; m0_addr = 16'h0040;
        applyStimulus();
        settle();
        checkOutput("ab_cs", bus_cs, 1'b1);
        applyStimulus();
        m0_cs = 1'b0;
        settle();
        checkOutput("ab_cs_drop", bus_cs, 1'b0);
        checkOutput("ab_noack", m0_ack, 1'b0);
        applyStimulus();
        s_ack = 1'b1; s_dat = 16'h7777;
        settle();
        checkOutput("ab_idle", grant, 2'b00);
        checkOutput("idle_ack_ignored", {m1_ack, m0_ack}, 2'b00);
        applyStimulus();
        clearInputs();

        // m0 completes (so m1 would win a tie), then reset mid-BUSY1
        applyStimulus();
        m0_cs = 1'b1; m0_addr = 16'h0050;
        applyStimulus();
        s_ack = 1'b1;
        applyStimulus();
        clearInputs();
        m1_cs = 1'b1; m1_addr = 16'h0060;
        applyStimulus();
        settle();
        checkOutput("rs_busy1", grant, 2'b10);
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0; m1_cs = 1'b0;
        settle();
        checkOutput("rs_grant", grant, 2'b00);
        checkOutput("rs_cs", bus_cs, 1'b0);
        checkOutput("rs_acks", {m1_ack, m0_ack}, 2'b00);
        applyStimulus();
        m0_cs = 1'b1; m1_cs = 1'b1;
        applyStimulus();
        s_ack = 1'b1;
        settle();
        checkOutput("rs_tie_m0", grant, 2'b01);
        applyStimulus();
        m0_cs = 1'b0; s_ack = 1'b0;
        applyStimulus();
        s_ack = 1'b1;
        applyStimulus();
        clearInputs();

        // Slave never acks an m0 read
        applyStimulus();
        m0_cs = 1'b1; m0_addr = 16'h0077;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus();
            settle();
            if (i < 16) begin
                checkOutput("to_wait_cs", bus_cs, 1'b1);
                checkOutput("to_wait_pulse", timeout, 1'b0);
            end
        end
`ifdef BUS_TIMEOUT_EN
        checkOutput("to_ack", m0_ack, 1'b1);
        checkOutput("to_dat", m0_rdat, 16'hFFFF);
        checkOutput("to_pulse", timeout, 1'b1);
        checkOutput("to_cs", bus_cs, 1'b0);
        applyStimulus();
        m0_cs = 1'b0;
        settle();
        checkOutput("to_idle", grant, 2'b00);

        // Ack exactly at the limit beats the watchdog
        applyStimulus();
        m0_cs = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus();
            if (i == 16) begin
                s_ack = 1'b1; s_dat = 16'h4321;
            end
        end
        settle();
        checkOutput("lim_ack", m0_ack, 1'b1);
        checkOutput("lim_dat", m0_rdat, 16'h4321);
        checkOutput("lim_pulse", timeout, 1'b0);
        applyStimulus();
        clearInputs();
`else
        checkOutput("hold_ack", m0_ack, 1'b0);
        checkOutput("hold_pulse", timeout, 1'b0);
        for (int i = 0; i < 24; i++) applyStimulus();
        settle();
        checkOutput("hold_grant", grant, 2'b01);
        checkOutput("hold_cs", bus_cs, 1'b1);
        applyStimulus();
        m0_cs = 1'b0;
        applyStimulus();
        settle();
        checkOutput("hold_release", grant, 2'b00);
`endif
        applyStimulus();
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcpu_bus_arb.md
Name: dcpu_bus_arb

Overview:
- Two-master, one-slave memory bus arbiter. It lets the dcpu core (master 0) share the single memory port with a second master (master 1: loader/DMA/debug).
- Uses the same cs/we/ack bus protocol as the core.
- Uses registered round-robin grant and holds the grant until the slave acks or the master drops its request.
- Sits between the core's bus pins and the memory/peripheral decoder.

Parameters:
- W, 16, address/data width.
- TOW, 4, width of the timeout counter (only used with BUS_TIMEOUT_EN).
- TIMEOUT, 15, number of busy cycles without i_ack before a forced termination (must be < 2^TOW).

Ports:
- i_clk  in  1  clock, all logic on posedge
- i_reset  in  1  synchronous, active-high reset
- i_m0_addr  in  W  master 0 address
- i_m0_dat  in  W  master 0 write data
- i_m0_we  in  1  master 0 write enable
- i_m0_cs  in  1  master 0 request
- o_m0_dat  out  W  read data to master 0
- o_m0_ack  out  1  ack to master 0
- i_m1_addr, i_m1_dat, i_m1_we, i_m1_cs  in  W/W/1/1  master 1 equivalents
- o_m1_dat  out  W  read data to master 1
- o_m1_ack  out  1  ack to master 1
- o_addr  out  W  slave address
- o_dat  out  W  slave write data
- o_we  out  1  slave write enable
- o_cs  out  1  slave chip select
- i_dat  in  W  slave read data
- i_ack  in  1  slave ack
- o_grant  out  2  one-hot current grant (bit n = master n)
- o_timeout  out  1  one-cycle pulse on forced termination

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is synchronous, active-high; it overrides all other inputs in the cycle it is sampled.
- Reset values:
  - state=IDLE, r_last=1 (so master 0 wins the first tie), o_grant=00, timeout counter=0.
  - All outputs 0: o_cs=0, o_we=0, o_addr=0, o_dat=0, o_mN_ack=0, o_mN_dat=0, o_timeout=0.
- States: IDLE, BUSY0, BUSY1. o_grant is registered: 01 in BUSY0, 10 in BUSY1, 00 in IDLE.
- IDLE:
  - Only m0_cs set -> BUSY0. Only m1_cs set -> BUSY1.
  - Both set -> grant the master != r_last.
  - Neither set -> stay in IDLE.
  - o_cs=0 throughout IDLE.
- BUSYn:
  - Slave outputs mux combinationally from master n: o_addr, o_dat, o_we, and o_cs = i_mn_cs.
  - The non-granted master sees ack=0 and dat=0.
  - o_mn_dat = i_dat while in BUSYn; o_mn_ack = i_ack & i_mn_cs (same cycle, combinational).
- Latency: request sampled in IDLE at cycle k -> o_cs high at cycle k+1. With a zero-wait slave, ack arrives at k+1.
- BUSYn exits to IDLE when any of the following holds:
  - i_ack=1: r_last<=n.
  - i_mn_cs=0 (abort): r_last unchanged, no ack issued.
  - Timeout (see Optional Feature).
- Turnaround: one IDLE cycle between consecutive transactions. Minimum 2 cycles per transaction with a zero-wait slave.
- Write path: o_we is driven only while granted. A write is complete when the slave acks; o_mn_dat content is don't-care but driven from i_dat.
- Boundary conditions:
  - i_ack while in IDLE is ignored; no master ack.
  - The ungranted master's cs may assert/deassert freely with no effect until IDLE.
  - Reset mid-transaction: o_cs drops the cycle after reset is sampled; no ack is delivered.
- Fairness: under continuous requests from both masters, grants alternate 0,1,0,1. Worst-case wait is one full transaction of the other master plus turnaround.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - TOW-bit counter clears in IDLE and increments each BUSY cycle without i_ack.
  - When the counter == TIMEOUT and i_ack=0: o_mn_ack=1, o_mn_dat={W{1'b1}}, o_cs forced 0, o_timeout=1 for that cycle.
  - Then -> IDLE with r_last<=n.
  - i_ack in the same cycle as the limit takes priority: normal ack, no timeout.
- Undefined: no counter; BUSY waits indefinitely; o_timeout tied 0.

Test Plan:
- Single read: m0 addr 0x0010 cs=1, slave acks next cycle with 0xBEEF -> o_cs high at cycle 1, o_m0_ack=1 with o_m0_dat=0xBEEF at cycle 1, IDLE at cycle 2, o_grant 00->01->00.
- Tie after reset: m0 and m1 request together -> m0 served first; m1 granted after one IDLE cycle; o_grant sequence 01,00,10.
- Round-robin: both masters hold cs continuously for 6 transactions, slave 1-wait -> grant order 0,1,0,1,0,1; no master starved.
- Write: m1 writes 0x1234 to 0x0100 -> o_we=1, o_addr=0x0100, o_dat=0x1234 while granted; o_m1_ack on slave ack; m0 sees no ack.
- Abort/reset: m0 drops cs before ack -> o_cs=0 the same cycle, no ack, IDLE next cycle. Assert i_reset mid-BUSY1 -> all outputs 0, state IDLE, next tie goes to m0.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT=15): slave never acks a m0 read -> o_m0_ack=1, o_m0_dat=0xFFFF, o_timeout pulse at the 16th BUSY cycle, then IDLE. Without the macro, the bus stays in BUSY0 indefinitely.
